// File: rtl/io_port_pkg.sv
// io_port_pkg: shared defaults, error-flag bit positions and the selector
// width helper used by the I/O port bank, its interface and its FIFOs.
package io_port_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  // Bit positions inside err_flags
  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;

  // Channel selector width; a single-channel bank still needs a 1-bit selector
  function automatic int ch_w(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// io_port_bank_if: CPU-side (IN/OUT instruction) and external-side
// (valid/ready) signals of the I/O port bank. The bank uses the slave
// modport; the CPU wrapper and external devices drive the master side.
interface io_port_bank_if #(
  parameter int DATA_W = io_port_pkg::DEF_DATA_W,
  parameter int NUM_CH = io_port_pkg::DEF_NUM_CH
);

  localparam int CH_W = io_port_pkg::ch_w(NUM_CH);

  // CPU side
  logic                     cpu_in_rd;
  logic [CH_W-1:0]          cpu_in_sel;
  logic [DATA_W-1:0]        cpu_in_data;
  logic                     cpu_out_wr;
  logic [CH_W-1:0]          cpu_out_sel;
  logic [DATA_W-1:0]        cpu_out_data;
  logic                     cpu_mask_wr;

  // External side
  logic [NUM_CH*DATA_W-1:0] ext_in_data;
  logic [NUM_CH-1:0]        ext_in_valid;
  logic [NUM_CH-1:0]        ext_in_ready;
  logic [NUM_CH*DATA_W-1:0] ext_out_data;
  logic [NUM_CH-1:0]        ext_out_valid;
  logic [NUM_CH-1:0]        ext_out_ready;

  // Status and interrupt
  logic [NUM_CH-1:0]        in_nonempty;
  logic [NUM_CH-1:0]        out_busy;
  logic [1:0]               err_flags;
  logic                     int_sig;

  modport master (
    output cpu_in_rd, cpu_in_sel, cpu_out_wr, cpu_out_sel, cpu_out_data,
           cpu_mask_wr, ext_in_data, ext_in_valid, ext_out_ready,
    input  cpu_in_data, ext_in_ready, ext_out_data, ext_out_valid,
           in_nonempty, out_busy, err_flags, int_sig
  );

  modport slave (
    input  cpu_in_rd, cpu_in_sel, cpu_out_wr, cpu_out_sel, cpu_out_data,
           cpu_mask_wr, ext_in_data, ext_in_valid, ext_out_ready,
    output cpu_in_data, ext_in_ready, ext_out_data, ext_out_valid,
           in_nonempty, out_busy, err_flags, int_sig
  );

endinterface

// File: rtl/io_fifo.sv
// io_fifo: single-clock synchronous FIFO for one input channel. Pointers
// wrap modulo DEPTH (a power of two); the count carries one extra bit so
// that full and empty are told apart. The head entry is shown on rdata.
module io_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: multi-channel I/O port bank for the CPU wrapper. Input
// channels buffer external bytes in io_fifo instances popped by IN; output
// channels hold one OUT byte until the external consumer takes it.
// Build option IO_PORT_IRQ_EN adds the interrupt mask register and a
// registered, level-sensitive int_sig; without it int_sig is tied low.
module io_port_bank
  import io_port_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic           clk,
  input logic           rstn,
  io_port_bank_if.slave bus
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0]        push;
  logic [NUM_CH-1:0]        pop;
  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        empty;
  logic [NUM_CH-1:0]        nonempty_next;
  logic [DATA_W-1:0]        head  [NUM_CH];
  logic [CNT_W-1:0]         count [NUM_CH];

  logic                     in_hit;
  logic                     in_empty_sel;
  logic [DATA_W-1:0]        in_head_sel;
  logic [DATA_W-1:0]        in_data_q;

  logic                     mask_wr;
  logic                     port_wr;
  logic [NUM_CH-1:0]        out_hs;
  logic [NUM_CH-1:0]        out_load;
  logic [NUM_CH-1:0]        out_drop;
  logic [NUM_CH-1:0]        out_valid_q;
  logic [NUM_CH*DATA_W-1:0] out_data_q;
  logic [1:0]               err_q;

  // Input channels: ready depends only on occupancy, so a pop in the same
  // cycle as a full FIFO never opens room for a push.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c] = bus.ext_in_valid[c] & ~full[c];
    assign pop[c]  = bus.cpu_in_rd & (bus.cpu_in_sel == CH_W'(c)) & ~empty[c];
    assign nonempty_next[c] = push[c] | (count[c] > CNT_W'(1)) | (~empty[c] & ~pop[c]);

    io_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push[c]),
      .pop   (pop[c]),
      .wdata (bus.ext_in_data[c*DATA_W +: DATA_W]),
      .rdata (head[c]),
      .full  (full[c]),
      .empty (empty[c]),
      .count (count[c])
    );
  end

  // Pick out the head byte and empty flag of the channel IN selects;
  // a selector past the last channel matches nothing.
  always_comb begin
    in_hit       = 1'b0;
    in_empty_sel = 1'b0;
    in_head_sel  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.cpu_in_sel == CH_W'(c)) begin
        in_hit       = 1'b1;
        in_empty_sel = empty[c];
        in_head_sel  = head[c];
      end
    end
  end

  // IN result register: head byte on a normal pop, zero on an empty pop
  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_data_q <= '0;
    end else if (bus.cpu_in_rd && in_hit) begin
      in_data_q <= in_empty_sel ? '0 : in_head_sel;
    end
  end

`ifdef IO_PORT_IRQ_EN
  assign mask_wr = bus.cpu_mask_wr;
`else
  assign mask_wr = 1'b0;
`endif

  // A mask write takes priority over a port write issued with it
  assign port_wr = bus.cpu_out_wr & ~mask_wr;
  assign out_hs  = out_valid_q & bus.ext_out_ready;

  // Decide per output channel whether an OUT loads or is dropped; a
  // handshake completing this cycle frees the holding register in time.
  always_comb begin
    out_load = '0;
    out_drop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (port_wr && (bus.cpu_out_sel == CH_W'(c))) begin
        if (!out_valid_q[c] || out_hs[c]) out_load[c] = 1'b1;
        else                              out_drop[c] = 1'b1;
      end
    end
  end

  // Output holding registers: load on accepted write, clear on handshake
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (out_load[c]) begin
          out_valid_q[c]                   <= 1'b1;
          out_data_q[c*DATA_W +: DATA_W] <= bus.cpu_out_data;
        end else if (out_hs[c]) begin
          out_valid_q[c] <= 1'b0;
        end
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= '0;
    end else begin
      if (bus.cpu_in_rd && in_hit && in_empty_sel) err_q[ERR_UNDERFLOW] <= 1'b1;
      if (|out_drop)                               err_q[ERR_OVERFLOW]  <= 1'b1;
    end
  end

`ifdef IO_PORT_IRQ_EN
  logic [NUM_CH-1:0] irq_mask;
  logic              int_q;

  // Mask register and interrupt request, computed from next-cycle occupancy
  // so int_sig rises on the same edge as in_nonempty.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_mask <= '0;
      int_q    <= 1'b0;
    end else begin
      if (bus.cpu_mask_wr) irq_mask <= bus.cpu_out_data[NUM_CH-1:0];
      int_q <= |(nonempty_next & irq_mask);
    end
  end

  assign bus.int_sig = int_q;
`else
  logic unused_irq;
  assign unused_irq  = ^{bus.cpu_mask_wr, nonempty_next};
  assign bus.int_sig = 1'b0;
`endif

  assign bus.cpu_in_data   = in_data_q;
  assign bus.ext_in_ready  = ~full;
  assign bus.in_nonempty   = ~empty;
  assign bus.ext_out_data  = out_data_q;
  assign bus.ext_out_valid = out_valid_q;
  assign bus.out_busy      = out_valid_q;
  assign bus.err_flags     = err_q;

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: self-checking bench for io_port_bank. A reference model
// keeps per-channel byte queues; each pop pushes its expected result onto a
// scoreboard queue that the scenario tasks compare against cpu_in_data.
// Interrupt expectations follow IO_PORT_IRQ_EN.
module tb_io_port_bank;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int FD = 4;

`ifdef IO_PORT_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  io_port_bank_if #(.DATA_W(DW), .NUM_CH(NC)) bus ();

  io_port_bank #(
    .DATA_W     (DW),
    .NUM_CH     (NC),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] model_q [NC][$];
  logic [DW-1:0] exp_pop_q [$];
  logic [DW-1:0] exp_out_data [NC];
  logic [NC-1:0] exp_out_valid;
  logic [1:0]    exp_err;
  logic [DW-1:0] e;

  function automatic logic [NC*DW-1:0] exp_out_packed();
    logic [NC*DW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*DW +: DW] = exp_out_data[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      model_q[c].delete();
      exp_out_data[c] = '0;
    end
    exp_pop_q.delete();
    exp_out_valid = '0;
    exp_err       = '0;
  endtask

  // One clock of stimulus; the model is advanced from pre-edge state
  task automatic step(input logic [NC-1:0] push_en, input logic [DW-1:0] push_byte,
                      input logic rd, input logic [1:0] rd_sel,
                      input logic wr, input logic [1:0] wr_sel, input logic [DW-1:0] wr_data,
                      input logic mask_wr);
    int            sz [NC];
    logic [NC-1:0] hs;
    logic [NC-1:0] new_valid;
    for (int c = 0; c < NC; c++) sz[c] = model_q[c].size();
    bus.ext_in_valid = push_en;
    bus.ext_in_data  = {NC{push_byte}};
    bus.cpu_in_rd    = rd;
    bus.cpu_in_sel   = rd_sel;
    bus.cpu_out_wr   = wr;
    bus.cpu_out_sel  = wr_sel;
    bus.cpu_out_data = wr_data;
    bus.cpu_mask_wr  = mask_wr;
    hs = exp_out_valid & bus.ext_out_ready;
    if (rd) begin
      if (sz[rd_sel] == 0) begin
        exp_pop_q.push_back('0);
        exp_err[0] = 1'b1;
      end else begin
        exp_pop_q.push_back(model_q[rd_sel].pop_front());
      end
    end
    for (int c = 0; c < NC; c++)
      if (push_en[c] && sz[c] < FD) model_q[c].push_back(push_byte);
    new_valid = exp_out_valid & ~hs;
    if (wr && !(IRQ_ON && mask_wr)) begin
      if (!exp_out_valid[wr_sel] || hs[wr_sel]) begin
        exp_out_data[wr_sel] = wr_data;
        new_valid[wr_sel]    = 1'b1;
      end else begin
        exp_err[1] = 1'b1;
      end
    end
    exp_out_valid = new_valid;
    @(posedge clk);
    #1;
    bus.ext_in_valid = '0;
    bus.cpu_in_rd    = 1'b0;
    bus.cpu_out_wr   = 1'b0;
    bus.cpu_mask_wr  = 1'b0;
  endtask

  task automatic idle();
    step('0, '0, 1'b0, 2'd0, 1'b0, 2'd0, '0, 1'b0);
  endtask

  task automatic push(input int ch, input logic [DW-1:0] b);
    step(NC'(1) << ch, b, 1'b0, 2'd0, 1'b0, 2'd0, '0, 1'b0);
  endtask

  task automatic pop(input int ch);
    step('0, '0, 1'b1, 2'(ch), 1'b0, 2'd0, '0, 1'b0);
  endtask

  task automatic push_pop(input int pch, input logic [DW-1:0] b, input int rch);
    step(NC'(1) << pch, b, 1'b1, 2'(rch), 1'b0, 2'd0, '0, 1'b0);
  endtask

  task automatic write(input int ch, input logic [DW-1:0] d);
    step('0, '0, 1'b0, 2'd0, 1'b1, 2'(ch), d, 1'b0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    idle();
    model_reset();
    checks++; if (bus.ext_in_ready !== 4'hF) $display("[TB] FAIL reset_in_ready: got %h expected %h", bus.ext_in_ready, 4'hF); else passes++;
    checks++; if (bus.in_nonempty !== 4'h0) $display("[TB] FAIL reset_nonempty: got %h expected %h", bus.in_nonempty, 4'h0); else passes++;
    checks++; if (bus.ext_out_valid !== 4'h0) $display("[TB] FAIL reset_out_valid: got %h expected %h", bus.ext_out_valid, 4'h0); else passes++;
    checks++; if (bus.out_busy !== 4'h0) $display("[TB] FAIL reset_out_busy: got %h expected %h", bus.out_busy, 4'h0); else passes++;
    checks++; if (bus.ext_out_data !== 32'h0) $display("[TB] FAIL reset_out_data: got %h expected %h", bus.ext_out_data, 32'h0); else passes++;
    checks++; if (bus.cpu_in_data !== 8'h00) $display("[TB] FAIL reset_in_data: got %h expected %h", bus.cpu_in_data, 8'h00); else passes++;
    checks++; if (bus.err_flags !== 2'b00) $display("[TB] FAIL reset_err: got %b expected %b", bus.err_flags, 2'b00); else passes++;
    checks++; if (bus.int_sig !== 1'b0) $display("[TB] FAIL reset_int: got %b expected %b", bus.int_sig, 1'b0); else passes++;
    rstn = 1'b1;
    idle();
  endtask

  task automatic test_single_push_pop();
    push(0, 8'h05);
    checks++; if (bus.in_nonempty !== 4'b0001) $display("[TB] FAIL push_nonempty: got %b expected %b", bus.in_nonempty, 4'b0001); else passes++;
    pop(0);
    e = exp_pop_q.pop_front();
    checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL pop_ch0_data: got %h expected %h", bus.cpu_in_data, e); else passes++;
    checks++; if (bus.in_nonempty !== 4'b0000) $display("[TB] FAIL pop_nonempty: got %b expected %b", bus.in_nonempty, 4'b0000); else passes++;
    idle();
    checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL in_data_hold: got %h expected %h", bus.cpu_in_data, e); else passes++;
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < FD; i++) push(1, 8'h11 + 8'(i));
    checks++; if (bus.ext_in_ready !== 4'b1101) $display("[TB] FAIL full_ready: got %b expected %b", bus.ext_in_ready, 4'b1101); else passes++;
    push_pop(1, 8'h15, 1);
    e = exp_pop_q.pop_front();
    checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL full_pop_data: got %h expected %h", bus.cpu_in_data, e); else passes++;
    checks++; if (bus.ext_in_ready[1] !== 1'b1) $display("[TB] FAIL full_pop_ready: got %b expected %b", bus.ext_in_ready[1], 1'b1); else passes++;
    for (int i = 0; i < 3; i++) begin
      pop(1);
      e = exp_pop_q.pop_front();
      checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL drain_ch1_%0d: got %h expected %h", i, bus.cpu_in_data, e); else passes++;
    end
    checks++; if (bus.in_nonempty[1] !== 1'b0) $display("[TB] FAIL drain_nonempty: got %b expected %b", bus.in_nonempty[1], 1'b0); else passes++;
    push(1, 8'h21);
    push(1, 8'h22);
    for (int i = 0; i < 2; i++) begin
      pop(1);
      e = exp_pop_q.pop_front();
      checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL wrap_ch1_%0d: got %h expected %h", i, bus.cpu_in_data, e); else passes++;
    end
  endtask

  task automatic test_underflow();
    pop(2);
    e = exp_pop_q.pop_front();
    checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL underflow_data: got %h expected %h", bus.cpu_in_data, e); else passes++;
    checks++; if (bus.err_flags !== exp_err) $display("[TB] FAIL underflow_err: got %b expected %b", bus.err_flags, exp_err); else passes++;
    push(1, 8'h33);
    pop(1);
    e = exp_pop_q.pop_front();
    checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL pop_after_underflow: got %h expected %h", bus.cpu_in_data, e); else passes++;
    push_pop(2, 8'h77, 2);
    e = exp_pop_q.pop_front();
    checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL empty_pop_with_push: got %h expected %h", bus.cpu_in_data, e); else passes++;
    checks++; if (bus.in_nonempty[2] !== 1'b1) $display("[TB] FAIL no_bypass_stored: got %b expected %b", bus.in_nonempty[2], 1'b1); else passes++;
    pop(2);
    e = exp_pop_q.pop_front();
    checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL stored_byte: got %h expected %h", bus.cpu_in_data, e); else passes++;
    idle();
    checks++; if (bus.err_flags !== exp_err) $display("[TB] FAIL underflow_sticky: got %b expected %b", bus.err_flags, exp_err); else passes++;
  endtask

  task automatic test_back_to_back();
    bus.ext_out_ready = 4'b0000;
    write(0, 8'h10);
    checks++; if (bus.ext_out_valid !== exp_out_valid) $display("[TB] FAIL wr_valid: got %b expected %b", bus.ext_out_valid, exp_out_valid); else passes++;
    checks++; if (bus.out_busy !== exp_out_valid) $display("[TB] FAIL wr_busy: got %b expected %b", bus.out_busy, exp_out_valid); else passes++;
    bus.ext_out_ready = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      write(0, 8'h20 + 8'(i));
      checks++; if (bus.ext_out_data !== exp_out_packed()) $display("[TB] FAIL b2b_data_%0d: got %h expected %h", i, bus.ext_out_data, exp_out_packed()); else passes++;
      checks++; if (bus.ext_out_valid !== exp_out_valid) $display("[TB] FAIL b2b_valid_%0d: got %b expected %b", i, bus.ext_out_valid, exp_out_valid); else passes++;
    end
    checks++; if (bus.err_flags !== exp_err) $display("[TB] FAIL b2b_no_err: got %b expected %b", bus.err_flags, exp_err); else passes++;
    idle();
    checks++; if (bus.ext_out_valid !== 4'b0000) $display("[TB] FAIL hs_clears_valid: got %b expected %b", bus.ext_out_valid, 4'b0000); else passes++;
    bus.ext_out_ready = 4'b0000;
  endtask

  task automatic test_out_overflow();
    write(3, 8'hA5);
    write(3, 8'h5A);
    checks++; if (bus.ext_out_data[31:24] !== 8'hA5) $display("[TB] FAIL busy_retains: got %h expected %h", bus.ext_out_data[31:24], 8'hA5); else passes++;
    checks++; if (bus.err_flags !== exp_err) $display("[TB] FAIL overflow_err: got %b expected %b", bus.err_flags, exp_err); else passes++;
    bus.ext_out_ready = 4'b1000;
    write(3, 8'h3C);
    checks++; if (bus.ext_out_data !== exp_out_packed()) $display("[TB] FAIL hs_write_data: got %h expected %h", bus.ext_out_data, exp_out_packed()); else passes++;
    checks++; if (bus.ext_out_valid !== exp_out_valid) $display("[TB] FAIL hs_write_valid: got %b expected %b", bus.ext_out_valid, exp_out_valid); else passes++;
    idle();
    bus.ext_out_ready = 4'b0000;
  endtask

  task automatic test_irq();
    step('0, '0, 1'b0, 2'd0, 1'b0, 2'd0, 8'h04, 1'b1);
    push(0, 8'h01);
    checks++; if (bus.int_sig !== 1'b0) $display("[TB] FAIL irq_unmasked_ch: got %b expected %b", bus.int_sig, 1'b0); else passes++;
    push(2, 8'h02);
    checks++; if (bus.int_sig !== IRQ_ON) $display("[TB] FAIL irq_masked_push: got %b expected %b", bus.int_sig, IRQ_ON); else passes++;
    pop(2);
    e = exp_pop_q.pop_front();
    checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL irq_pop_data: got %h expected %h", bus.cpu_in_data, e); else passes++;
    checks++; if (bus.int_sig !== 1'b0) $display("[TB] FAIL irq_drained: got %b expected %b", bus.int_sig, 1'b0); else passes++;
    pop(0);
    e = exp_pop_q.pop_front();
    checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL irq_pop_ch0: got %h expected %h", bus.cpu_in_data, e); else passes++;
`ifdef IO_PORT_IRQ_EN
    step('0, '0, 1'b0, 2'd0, 1'b1, 2'd1, 8'h00, 1'b1);
    checks++; if (bus.ext_out_valid !== exp_out_valid) $display("[TB] FAIL mask_wins: got %b expected %b", bus.ext_out_valid, exp_out_valid); else passes++;
    push(2, 8'h03);
    checks++; if (bus.int_sig !== 1'b0) $display("[TB] FAIL mask_cleared: got %b expected %b", bus.int_sig, 1'b0); else passes++;
    pop(2);
    e = exp_pop_q.pop_front();
`endif
  endtask

  task automatic test_throughput();
    push(0, 8'h40);
    for (int i = 1; i < 8; i++) begin
      push_pop(0, 8'h40 + 8'(i), 0);
      e = exp_pop_q.pop_front();
      checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL stream_%0d: got %h expected %h", i, bus.cpu_in_data, e); else passes++;
    end
    pop(0);
    e = exp_pop_q.pop_front();
    checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL stream_last: got %h expected %h", bus.cpu_in_data, e); else passes++;
  endtask

  task automatic test_mid_reset();
    push(1, 8'h99);
    write(2, 8'h55);
    rstn = 1'b0;
    idle();
    model_reset();
    checks++; if (bus.in_nonempty !== 4'h0) $display("[TB] FAIL midreset_nonempty: got %b expected %b", bus.in_nonempty, 4'h0); else passes++;
    checks++; if (bus.ext_out_valid !== 4'h0) $display("[TB] FAIL midreset_out_valid: got %b expected %b", bus.ext_out_valid, 4'h0); else passes++;
    checks++; if (bus.ext_out_data !== 32'h0) $display("[TB] FAIL midreset_out_data: got %h expected %h", bus.ext_out_data, 32'h0); else passes++;
    checks++; if (bus.err_flags !== 2'b00) $display("[TB] FAIL midreset_err: got %b expected %b", bus.err_flags, 2'b00); else passes++;
    rstn = 1'b1;
    pop(1);
    e = exp_pop_q.pop_front();
    checks++; if (bus.cpu_in_data !== e) $display("[TB] FAIL midreset_discard: got %h expected %h", bus.cpu_in_data, e); else passes++;
    checks++; if (bus.err_flags !== exp_err) $display("[TB] FAIL midreset_underflow: got %b expected %b", bus.err_flags, exp_err); else passes++;
  endtask

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passes, checks);
    $fatal(1, "[TB] time limit");
  end

  initial begin
    bus.cpu_in_rd     = 1'b0;
    bus.cpu_in_sel    = '0;
    bus.cpu_out_wr    = 1'b0;
    bus.cpu_out_sel   = '0;
    bus.cpu_out_data  = '0;
    bus.cpu_mask_wr   = 1'b0;
    bus.ext_in_data   = '0;
    bus.ext_in_valid  = '0;
    bus.ext_out_ready = '0;
    model_reset();
    test_reset();
    test_single_push_pop();
    test_full_wrap();
    test_underflow();
    test_back_to_back();
    test_out_overflow();
    test_irq();
    test_throughput();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised multi-channel I/O port bank that replaces the single raw `I_Port`/`O_Port` pair of `CPU_WrapperV3`. Each input channel buffers external bytes in a small FIFO with a valid/ready handshake; each output channel holds one CPU-written byte until the external consumer accepts it. The bank raises a maskable, level-sensitive interrupt toward the CPU's `int_sig` input. The CPU's IN and OUT instructions drive the `cpu_*` side, with the channel selected by the instruction's register field.

## Interface
- `DATA_W`, 8: channel data width.
- `NUM_CH`, 4: number of input channels and number of output channels; range 1–4.
- `FIFO_DEPTH`, 4: entries per input FIFO; must be a power of two, ≥2.
- `clk` in 1: single clock; all logic is clocked on the rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `cpu_in_rd` in 1: IN-instruction pop strobe.
- `cpu_in_sel` in CH_W: input channel to pop; CH_W = max(1, clog2(NUM_CH)).
- `cpu_in_data` out DATA_W: registered pop result.
- `cpu_out_wr` in 1: OUT-instruction write strobe.
- `cpu_out_sel` in CH_W: output channel to write.
- `cpu_out_data` in DATA_W: write data; bits [NUM_CH-1:0] also carry the mask on a mask write.
- `cpu_mask_wr` in 1: load `irq_mask` from `cpu_out_data[NUM_CH-1:0]`.
- `ext_in_data` in NUM_CH*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
- `ext_in_valid` in NUM_CH: external producer valid.
- `ext_in_ready` out NUM_CH: FIFO not full.
- `ext_out_data` out NUM_CH*DATA_W: held output bytes.
- `ext_out_valid` out NUM_CH: output byte pending.
- `ext_out_ready` in NUM_CH: external consumer ready.
- `in_nonempty` out NUM_CH: status, per-channel FIFO not empty.
- `out_busy` out NUM_CH: equals `ext_out_valid`; the CPU stalls OUT while this is set.
- `err_flags` out 2: bit0 = sticky underflow, bit1 = sticky overflow.
- `int_sig` out 1: interrupt request.

## Operation
- Input push: when `ext_in_valid[c]` and `ext_in_ready[c]` are both high, the byte is pushed. `ext_in_ready[c] = (count_c != FIFO_DEPTH)` and depends only on count; it never depends on same-cycle CPU strobes.
- Full FIFO with a pop in the same cycle: the pop is performed and no push occurs, because ready was already low.
- Input pop: `cpu_in_rd` with a non-empty selected FIFO pops the head into `cpu_in_data`.
- Pop on an empty FIFO: `cpu_in_data` is loaded with 0 and `err_flags[0]` is set. This holds even if a push arrives in the same cycle; there is no bypass, and the pushed byte is stored.
- `cpu_in_data` holds its value when no pop occurs.
- Output write: `cpu_out_wr` to a channel with `ext_out_valid` low loads data and sets valid.
- Output write to a busy channel: the data is dropped and `err_flags[1]` is set.
- Same-cycle write and handshake on one channel: if a handshake (valid & ready) completes in the same cycle as a write, the new data loads, valid stays 1, and no error is flagged.
- Handshake without a write: valid clears.
- Selector range: an out-of-range `cpu_in_sel`/`cpu_out_sel` (≥ NUM_CH) is ignored, and no error is flagged.
- Mask write: `cpu_mask_wr` and `cpu_out_wr` are mutually exclusive. If both are asserted, the mask write wins and the port write is ignored.
- Interrupt: `int_sig` is registered: `int_sig <= |(in_nonempty_next & irq_mask)`. It stays high until every masked channel has been drained.
- FIFO pointers are clog2(FIFO_DEPTH) bits and wrap modulo depth. Count is clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: all FIFOs empty, `ext_in_ready` all 1, `ext_out_valid` 0, `ext_out_data` 0, `cpu_in_data` 0, `irq_mask` 0, `err_flags` 0, `int_sig` 0.
- Reset mid-operation discards FIFO contents and pending outputs in the same edge.
- Pop latency: strobe at edge N, data valid after edge N, i.e. usable in cycle N+1.
- Push-to-`in_nonempty`: 1 cycle. Push-to-`int_sig`: 1 cycle (same edge as `in_nonempty`).
- Output write to `ext_out_valid`: 1 cycle.
- Back-to-back writes are accepted at one per cycle when the consumer holds ready high.
- Sustained throughput: one push and one pop per channel per cycle.

## Configuration
- `IO_PORT_IRQ_EN` defined: the mask register, `cpu_mask_wr` and the `int_sig` logic are present as described.
- `IO_PORT_IRQ_EN` undefined: `int_sig` is tied to 0, `cpu_mask_wr` is ignored, and no mask flops are inferred. All other behaviour is identical.

## Structure
- Package `io_port_pkg` holds:
  - function `ch_w(n)`;
  - localparams `ERR_UNDERFLOW=0` and `ERR_OVERFLOW=1`;
  - the default `DATA_W`, `NUM_CH` and `FIFO_DEPTH` values.
- Sub-module `io_fifo` (params `DATA_W`, `DEPTH`) holds the per-channel sync FIFO with push, pop, full, empty and count. It is instantiated NUM_CH times in a generate loop.
- Output holding registers and the interrupt logic live in the top level.

## Test plan
- Reset, then push 0x05 on ch0; pop ch0 → `cpu_in_data`=0x05 one cycle after the strobe; `in_nonempty[0]` returns to 0.
- Push 4 bytes 0x11–0x14 into ch1 → `ext_in_ready[1]`=0. Then pop and push in the same cycle → the pop returns 0x11 and the 5th byte is not accepted. Drain → 0x12, 0x13, 0x14 in order, with wrap-around verified.
- Pop empty ch2 → `cpu_in_data`=0x00 and `err_flags`=2'b01, persisting until reset.
- Write 0xA5 to ch3 with `ext_out_ready`=0, then write 0x5A → 0xA5 is retained and `err_flags[1]`=1. Next, hold `ext_out_ready`=1 and write 0x3C in the handshake cycle → 0x3C is presented with valid still 1.
- Write mask 4'b0100, push on ch0 → `int_sig` stays 0. Push on ch2 → `int_sig`=1 one cycle later. Pop ch2 → `int_sig`=0 one cycle later.
- Build without `IO_PORT_IRQ_EN`, repeat the previous scenario → `int_sig` is constantly 0.
